mmio_display_port: RTL

MMIO_DISPLAY_PORT -- requirements
Module: mmio_display_port

---
 rtl/mmio_pkg.sv | 14 +
 rtl/display_fifo.sv | 69 ++++++
 rtl/mmio_display_port.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared addresses, display FSM states and default dwell for mmio_display_port
package mmio_pkg;

  localparam logic [31:0] DISP_ADDR_DEF    = 32'hFFFF_0000;
  localparam logic [31:0] LED_ADDR_DEF     = 32'hFFFF_0004;
  localparam logic [31:0] CTRL_ADDR_DEF    = 32'hFFFF_0008;
  localparam int unsigned DWELL_CYCLES_DEF = 25_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_e;

endpackage

// File: rtl/display_fifo.sv
// rtl/display_fifo.sv - small register-based queue of pending display values
// Head entry is presented combinationally on data; a full queue accepts a push when popped at the same edge.
module display_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are AW bits wide so they wrap modulo DEPTH for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_display_port.sv
// rtl/mmio_display_port.sv - memory-mapped seven-segment value and LED output port
// Define MMIO_DISPLAY_DWELL_EN to queue display stores and hold each value for DWELL_CYCLES.
module mmio_display_port
  import mmio_pkg::*;
#(
  parameter logic [31:0] DISP_ADDR    = DISP_ADDR_DEF,
  parameter logic [31:0] LED_ADDR     = LED_ADDR_DEF,
  parameter logic [31:0] CTRL_ADDR    = CTRL_ADDR_DEF,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] value_to_display,
  output logic [15:0] led,
  output logic        queue_full,
  output logic        overflow
);

  logic        disp_wr, led_wr, ctrl_wr;
  logic [15:0] led_q, led_d;
  logic [31:0] value_q, value_d;

  assign disp_wr = wr_en && (wr_addr == DISP_ADDR);
  assign led_wr  = wr_en && (wr_addr == LED_ADDR);
  assign ctrl_wr = wr_en && (wr_addr == CTRL_ADDR);

  always_comb begin
    led_d = led_q;
    if (led_wr) begin
      led_d = wr_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      value_q <= '0;
    end else begin
      led_q   <= led_d;
      value_q <= value_d;
    end
  end

  assign led              = led_q;
  assign value_to_display = value_q;

`ifdef MMIO_DISPLAY_DWELL_EN

  localparam int unsigned CW  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned QCW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  disp_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           fifo_pop, fifo_full, fifo_empty, drop;
  logic [31:0]    fifo_data;
  logic [QCW-1:0] fifo_count;

  display_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (disp_wr),
    .pop   (fifo_pop),
    .din   (wr_data),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign drop = disp_wr && fifo_full && !fifo_pop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          value_d  = fifo_data;
          cnt_d    = '0;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            value_d  = fifo_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // A dropped store outranks a clear landing on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ctrl_wr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign queue_full = (fifo_count == QCW'(DEPTH));
  assign overflow   = ovf_q;

`else

  logic [64:0] unused_cfg;

  always_comb begin
    value_d = value_q;
    if (disp_wr) begin
      value_d = wr_data;
    end
  end

  assign unused_cfg = {ctrl_wr, 32'(DEPTH), 32'(DWELL_CYCLES)};
  assign queue_full = 1'b0;
  assign overflow   = 1'b0;

`endif

endmodule
